riscv_core_pc_unit: RTL and testbench
=====================================

RISCV_CORE_PC_UNIT -- requirements
Module: riscv_core_pc_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the datapath and PC width.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 64'h0000_0000_8000_0000, giving the PC loaded at reset.
REQ-003 The block SHALL have parameter FLUSH_CYCLES, default 2, range 1-7, giving the number of request-suppressed cycles after a redirect.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous reset, active low.
REQ-005 The block SHALL have these redirect and control inputs:
- i_pc_unit_stall  input  1  hold the PC; no advance.
- i_pc_unit_istaken  input  1  conditional branch resolved taken (branch unit).
- i_pc_unit_addr_mismatch  input  1  taken branch target misaligned (branch unit).
- i_pc_unit_branch_target  input  XLEN  conditional branch target.
- i_pc_unit_jump  input  1  JAL/JALR resolved.
- i_pc_unit_jump_target  input  XLEN  jump target, bit0 not yet cleared.
- i_pc_unit_trap_vector  input  XLEN  exception handler address.
- i_pc_unit_is_compressed  input  1  the instruction at o_pc_unit_pc is 16-bit.
- i_pc_unit_req_ready  input  1  instruction memory accepts the request.
REQ-006 The block SHALL have these outputs:
- o_pc_unit_req_valid  output  1  fetch request valid.
- o_pc_unit_pc  output  XLEN  current fetch PC.
- o_pc_unit_flush  output  1  kill younger in-flight instructions.
- o_pc_unit_misaligned_exc  output  1  one-cycle misaligned-target exception pulse.
- o_pc_unit_epc  output  XLEN  branch target that caused the exception.
- o_pc_unit_redirect_cnt  output  32  saturating count of accepted redirects.

Function
REQ-007 The block SHALL implement the states BOOT, RUN and FLUSH.
REQ-008 In BOOT, req_valid SHALL be 0, and the state SHALL advance to RUN unconditionally after one cycle.
REQ-009 In RUN, req_valid SHALL be 1; events SHALL be evaluated each cycle in this priority: addr_mismatch, istaken, jump, stall, handshake.
REQ-010 On addr_mismatch in RUN, the block SHALL do all of the following on that edge:
- pc <= trap_vector with bit0 cleared.
- epc <= branch_target.
- misaligned_exc = 1 for the next cycle.
- go to FLUSH.
REQ-011 On istaken without mismatch in RUN, the block SHALL do pc <= branch_target and go to FLUSH.
REQ-012 On jump without istaken in RUN, the block SHALL do pc <= jump_target with bit0 cleared and go to FLUSH.
REQ-013 When istaken and jump are both asserted, istaken SHALL win.
REQ-014 When stall=1 or req_ready=0 with no redirect, the block SHALL hold pc; a redirect SHALL be accepted even while stalled.
REQ-015 When req_valid & req_ready & !stall with no redirect, the block SHALL advance pc by 2 if is_compressed and by 4 otherwise.
REQ-016 PC arithmetic SHALL be modulo 2^XLEN; for example, 64'hFFFF_FFFF_FFFF_FFFE + 4 = 64'h2.
REQ-017 On entry to FLUSH, a 3-bit counter SHALL load FLUSH_CYCLES-1.
REQ-018 In FLUSH, the block SHALL drive flush=1 and req_valid=0, and decrement the counter each cycle.
REQ-019 FLUSH SHALL return to RUN on the cycle after the counter reads 0.
REQ-020 All redirect inputs SHALL be ignored in FLUSH, because they originate from killed instructions.
REQ-021 misaligned_exc SHALL be high for exactly one cycle per accepted mismatch.
REQ-022 epc SHALL hold its value until the next accepted mismatch.
REQ-023 redirect_cnt SHALL increment by 1 on every accepted redirect (mismatch, branch or jump) and saturate at 32'hFFFF_FFFF.
REQ-024 o_pc_unit_pc SHALL be driven directly from a register, with no combinational path from any input.
REQ-025 Redirect-to-pc latency SHALL be 1 cycle; the first fetch of the new target SHALL issue FLUSH_CYCLES+1 cycles after the redirect edge.

Reset
REQ-026 While i_rst_n=0, the block SHALL asynchronously force all of the following:
- state=BOOT, pc=RESET_VECTOR, epc=0, redirect_cnt=0, flush counter=0.
- req_valid=0, flush=0, misaligned_exc=0.
REQ-027 Reset asserted mid-FLUSH or mid-stall SHALL abandon the operation with no residual pulse.
REQ-028 After reset release, the first request SHALL issue with pc=RESET_VECTOR on the second rising edge.

Verification
REQ-029 Reset release, ready=1, no compressed instructions -> req_valid rises one cycle after BOOT; pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008.
REQ-030 Mixed sizes: is_compressed=1,0,1 starting at 0x8000_0000 -> pc sequence 0x8000_0000, 0x8000_0002, 0x8000_0006, 0x8000_0008.
REQ-031 istaken=1, target=0x8000_0100, FLUSH_CYCLES=2 -> pc=0x8000_0100 next cycle; flush=1 and req_valid=0 for 2 cycles; then req_valid=1; redirect_cnt=1.
REQ-032 istaken=1 and addr_mismatch=1, target=0x8000_0101, trap_vector=0x8000_0200 -> pc=0x8000_0200, epc=0x8000_0101, misaligned_exc=1 for one cycle.
REQ-033 istaken=1 and jump=1 in the same cycle (targets 0x100 and 0x200) -> pc=0x100; jump=1 during FLUSH is ignored.
REQ-034 stall=1 for 3 cycles, then ready=0 for 2 cycles -> pc constant throughout; reset pulse mid-FLUSH -> pc=RESET_VECTOR and flush=0 immediately.

Source files
------------

// File: rtl/riscv_core_pc_unit.sv
// Fetch PC generator: sequential advance, branch/jump/misaligned-trap redirect, post-redirect flush window.
// state | meaning: BOOT = one idle cycle after reset; RUN = fetching; FLUSH = requests suppressed after redirect
module riscv_core_pc_unit #(
  parameter int                XLEN         = 64,
  parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(64'h0000_0000_8000_0000),
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pc_unit_stall,
  input  logic            i_pc_unit_istaken,
  input  logic            i_pc_unit_addr_mismatch,
  input  logic [XLEN-1:0] i_pc_unit_branch_target,
  input  logic            i_pc_unit_jump,
  input  logic [XLEN-1:0] i_pc_unit_jump_target,
  input  logic [XLEN-1:0] i_pc_unit_trap_vector,
  input  logic            i_pc_unit_is_compressed,
  input  logic            i_pc_unit_req_ready,
  output logic            o_pc_unit_req_valid,
  output logic [XLEN-1:0] o_pc_unit_pc,
  output logic            o_pc_unit_flush,
  output logic            o_pc_unit_misaligned_exc,
  output logic [XLEN-1:0] o_pc_unit_epc,
  output logic [31:0]     o_pc_unit_redirect_cnt
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

  localparam logic [2:0]      FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic [31:0]     r_redirect_cnt;
  logic [2:0]      r_flush_cnt;
  logic            r_misaligned_exc;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_epc_nxt;
  logic [XLEN-1:0] w_pc_step;
  logic [2:0]      w_flush_cnt_nxt;
  logic            w_exc_nxt;
  logic            w_redirect;
  logic            w_req_valid;
  logic            w_flush;

  assign w_pc_step = i_pc_unit_is_compressed ? XLEN'(2) : XLEN'(4);

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_epc_nxt       = r_epc;
    w_flush_cnt_nxt = r_flush_cnt;
    w_exc_nxt       = 1'b0;
    w_redirect      = 1'b0;
    w_req_valid     = 1'b0;
    w_flush         = 1'b0;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        w_req_valid = 1'b1;
        if (i_pc_unit_addr_mismatch) begin
          w_pc_nxt   = i_pc_unit_trap_vector & ALIGN_MASK;
          w_epc_nxt  = i_pc_unit_branch_target;
          w_exc_nxt  = 1'b1;
          w_redirect = 1'b1;
        end else if (i_pc_unit_istaken) begin
          w_pc_nxt   = i_pc_unit_branch_target;
          w_redirect = 1'b1;
        end else if (i_pc_unit_jump) begin
          w_pc_nxt   = i_pc_unit_jump_target & ALIGN_MASK;
          w_redirect = 1'b1;
        end else if (!i_pc_unit_stall && i_pc_unit_req_ready) begin
          w_pc_nxt = r_pc + w_pc_step;
        end
        if (w_redirect) begin
          w_state_nxt     = S_FLUSH;
          w_flush_cnt_nxt = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        // Redirect inputs here come from killed instructions and are ignored.
        w_flush = 1'b1;
        if (r_flush_cnt == 3'd0) w_state_nxt = S_RUN;
        else                     w_flush_cnt_nxt = r_flush_cnt - 3'd1;
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_BOOT;
      r_pc             <= RESET_VECTOR;
      r_epc            <= '0;
      r_redirect_cnt   <= '0;
      r_flush_cnt      <= '0;
      r_misaligned_exc <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_pc             <= w_pc_nxt;
      r_epc            <= w_epc_nxt;
      r_flush_cnt      <= w_flush_cnt_nxt;
      r_misaligned_exc <= w_exc_nxt;
      if (w_redirect && (r_redirect_cnt != 32'hFFFF_FFFF))
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign o_pc_unit_req_valid      = w_req_valid;
  assign o_pc_unit_flush          = w_flush;
  assign o_pc_unit_pc             = r_pc;
  assign o_pc_unit_epc            = r_epc;
  assign o_pc_unit_misaligned_exc = r_misaligned_exc;
  assign o_pc_unit_redirect_cnt   = r_redirect_cnt;

endmodule

// File: tb/tb_riscv_core_pc_unit.sv
// Directed bench for riscv_core_pc_unit: boot, sequential fetch, stalls, redirects, flush window, reset mid-flush, wrap.
module tb_riscv_core_pc_unit;

  localparam logic [63:0] RV = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, istaken, mismatch, jump, is_c, ready;
  logic [63:0] br_tgt, jmp_tgt, trap_vec;
  logic        req_valid, flush, exc;
  logic [63:0] pc, epc;
  logic [31:0] rcnt;

  int n_pass = 0;
  int n_total = 0;

  riscv_core_pc_unit #(.XLEN(64), .RESET_VECTOR(RV), .FLUSH_CYCLES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pc_unit_stall(stall), .i_pc_unit_istaken(istaken),
    .i_pc_unit_addr_mismatch(mismatch), .i_pc_unit_branch_target(br_tgt),
    .i_pc_unit_jump(jump), .i_pc_unit_jump_target(jmp_tgt),
    .i_pc_unit_trap_vector(trap_vec), .i_pc_unit_is_compressed(is_c),
    .i_pc_unit_req_ready(ready),
    .o_pc_unit_req_valid(req_valid), .o_pc_unit_pc(pc), .o_pc_unit_flush(flush),
    .o_pc_unit_misaligned_exc(exc), .o_pc_unit_epc(epc),
    .o_pc_unit_redirect_cnt(rcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; istaken = 0; mismatch = 0; jump = 0; is_c = 0; ready = 1;
    br_tgt = '0; jmp_tgt = '0; trap_vec = '0;
    repeat (2) step();
    chk("rst_pc", pc, RV);
    chk("rst_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_flush", {63'd0, flush}, 64'd0);
    chk("rst_exc", {63'd0, exc}, 64'd0);
    chk("rst_epc", epc, 64'd0);
    chk("rst_cnt", {32'd0, rcnt}, 64'd0);

    rst_n = 1'b1;
    chk("boot_valid", {63'd0, req_valid}, 64'd0);
    step();
    chk("run_valid", {63'd0, req_valid}, 64'd1);
    chk("seq_pc0", pc, 64'h8000_0000);
    step();
    chk("seq_pc1", pc, 64'h8000_0004);
    step();
    chk("seq_pc2", pc, 64'h8000_0008);

    // mixed sizes from a fresh reset
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step();
    chk("mix_pc0", pc, 64'h8000_0000);
    is_c = 1; step();
    chk("mix_pc1", pc, 64'h8000_0002);
    is_c = 0; step();
    chk("mix_pc2", pc, 64'h8000_0006);
    is_c = 1; step();
    chk("mix_pc3", pc, 64'h8000_0008);
    is_c = 0;

    stall = 1;
    for (int i = 0; i < 3; i++) begin step(); chk("stall_pc", pc, 64'h8000_0008); end
    stall = 0; ready = 0;
    for (int i = 0; i < 2; i++) begin step(); chk("notready_pc", pc, 64'h8000_0008); end
    ready = 1;

    // taken branch, then a jump during FLUSH that must be ignored
    istaken = 1; br_tgt = 64'h8000_0100;
    step();
    istaken = 0; jump = 1; jmp_tgt = 64'h200;
    chk("br_pc", pc, 64'h8000_0100);
    chk("br_flush1", {63'd0, flush}, 64'd1);
    chk("br_valid1", {63'd0, req_valid}, 64'd0);
    chk("br_cnt", {32'd0, rcnt}, 64'd1);
    step();
    chk("br_flush2", {63'd0, flush}, 64'd1);
    chk("br_valid2", {63'd0, req_valid}, 64'd0);
    chk("br_pc_hold", pc, 64'h8000_0100);
    jump = 0;
    step();
    chk("br_flush_end", {63'd0, flush}, 64'd0);
    chk("br_valid_back", {63'd0, req_valid}, 64'd1);
    chk("br_pc_after", pc, 64'h8000_0100);
    chk("br_cnt_after", {32'd0, rcnt}, 64'd1);

    // misaligned taken branch
    istaken = 1; mismatch = 1; br_tgt = 64'h8000_0101; trap_vec = 64'h8000_0200;
    step();
    istaken = 0; mismatch = 0;
    chk("mm_pc", pc, 64'h8000_0200);
    chk("mm_epc", epc, 64'h8000_0101);
    chk("mm_exc", {63'd0, exc}, 64'd1);
    chk("mm_cnt", {32'd0, rcnt}, 64'd2);
    step();
    chk("mm_exc_drop", {63'd0, exc}, 64'd0);
    step();
    chk("mm_valid_back", {63'd0, req_valid}, 64'd1);
    chk("mm_epc_hold", epc, 64'h8000_0101);

    // branch beats jump; jump held through FLUSH is ignored, then taken in RUN
    istaken = 1; br_tgt = 64'h100; jump = 1; jmp_tgt = 64'h201;
    step();
    istaken = 0;
    chk("bj_pc", pc, 64'h100);
    chk("bj_cnt", {32'd0, rcnt}, 64'd3);
    step();
    step();
    chk("bj_pc_flush_ignored", pc, 64'h100);
    chk("bj_cnt_flush_ignored", {32'd0, rcnt}, 64'd3);
    step();
    jump = 0;
    chk("jmp_pc_aligned", pc, 64'h200);
    chk("jmp_cnt", {32'd0, rcnt}, 64'd4);
    chk("jmp_flush", {63'd0, flush}, 64'd1);

    // reset mid-FLUSH
    #2; rst_n = 1'b0; #1;
    chk("midrst_pc", pc, RV);
    chk("midrst_flush", {63'd0, flush}, 64'd0);
    chk("midrst_valid", {63'd0, req_valid}, 64'd0);
    chk("midrst_cnt", {32'd0, rcnt}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("midrst_run_pc", pc, RV);
    chk("midrst_run_flush", {63'd0, flush}, 64'd0);

    // redirect accepted while stalled, then modulo wrap
    stall = 1; istaken = 1; br_tgt = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    stall = 0; istaken = 0;
    chk("stall_br_pc", pc, 64'hFFFF_FFFF_FFFF_FFFE);
    step(); step();
    chk("wrap_valid", {63'd0, req_valid}, 64'd1);
    step();
    chk("wrap_pc", pc, 64'h2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
